// File: rtl/div_iter_pkg.sv
// Shared constants and FSM encoding for the iterative restoring divider.
// The latency constant is used by requesters and by the bench.
package div_iter_pkg;

    localparam int DIV_DATA_W  = 32;
    localparam int DIV_ITERS   = 32;
    localparam int DIV_LATENCY = 35;

    localparam logic [DIV_DATA_W-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_e;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate, used both to take operand
// magnitudes and to restore result signs.
module div_sign_fix
    import div_iter_pkg::*;
#(
    parameter int W = DIV_DATA_W
) (
    input  logic [W-1:0] a,
    input  logic         neg,
    output logic [W-1:0] y
);

    assign y = neg ? (~a + W'(1)) : a;

endmodule

// File: rtl/div_iter.sv
// Fixed-latency radix-2 restoring divider for signed/unsigned 32-bit
// DIV/MOD; one result per request, signalled by a single div_complete pulse.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              div,
    input  logic              div_signed,
    input  logic              div_cancel,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    output logic [DATA_W-1:0] s,
    output logic [DATA_W-1:0] r,
    output logic              div_complete,
    output logic              div_busy
);

    localparam int CNT_W  = $clog2(DIV_ITERS);
    localparam int WORK_W = 2 * DATA_W;

    div_state_e state_reg, state_next;

    logic [DATA_W-1:0] x_reg, y_reg, ymag_reg;
    logic              sign_reg, q_neg_reg, r_neg_reg, y_zero_reg;
    logic [WORK_W-1:0] work_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [DATA_W-1:0] s_reg, r_reg;

    logic [DATA_W-1:0] x_mag, y_mag, q_fix, r_fix, trial_low;
    logic              trial_ok, start;

    assign start = (state_reg == ST_IDLE) && div && !div_cancel;

    div_sign_fix #(.W(DATA_W)) u_abs_x (
        .a   (x_reg),
        .neg (sign_reg & x_reg[DATA_W-1]),
        .y   (x_mag)
    );

    div_sign_fix #(.W(DATA_W)) u_abs_y (
        .a   (y_reg),
        .neg (sign_reg & y_reg[DATA_W-1]),
        .y   (y_mag)
    );

    div_sign_fix #(.W(DATA_W)) u_fix_q (
        .a   (work_reg[DATA_W-1:0]),
        .neg (q_neg_reg),
        .y   (q_fix)
    );

    div_sign_fix #(.W(DATA_W)) u_fix_r (
        .a   (work_reg[WORK_W-1:DATA_W]),
        .neg (r_neg_reg),
        .y   (r_fix)
    );

    // Partial remainder is always < |y|, so the shifted value fits in
    // DATA_W+1 bits and the difference always fits back in DATA_W.
    assign trial_ok  = work_reg[WORK_W-1:DATA_W-1] >= {1'b0, ymag_reg};
    assign trial_low = work_reg[WORK_W-2:DATA_W-1] - ymag_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        div_busy     = 1'b0;
        div_complete = 1'b0;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_PREP;
            ST_PREP: state_next = ST_ITER;
            ST_ITER: if (count_reg == CNT_W'(DIV_ITERS - 1)) state_next = ST_FIX;
            ST_FIX:  state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (div_cancel && state_reg != ST_IDLE) begin
            state_next = ST_IDLE;
        end
        div_busy     = (state_reg == ST_PREP) || (state_reg == ST_ITER) ||
                       (state_reg == ST_FIX);
        div_complete = (state_reg == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_reg      <= '0;
            y_reg      <= '0;
            ymag_reg   <= '0;
            sign_reg   <= 1'b0;
            q_neg_reg  <= 1'b0;
            r_neg_reg  <= 1'b0;
            y_zero_reg <= 1'b0;
            work_reg   <= '0;
            count_reg  <= '0;
            s_reg      <= '0;
            r_reg      <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        x_reg    <= x;
                        y_reg    <= y;
                        sign_reg <= div_signed;
                    end
                end
                ST_PREP: begin
                    work_reg   <= {{DATA_W{1'b0}}, x_mag};
                    ymag_reg   <= y_mag;
                    q_neg_reg  <= sign_reg & (x_reg[DATA_W-1] ^ y_reg[DATA_W-1]);
                    r_neg_reg  <= sign_reg & x_reg[DATA_W-1];
                    y_zero_reg <= (y_reg == '0);
                    count_reg  <= '0;
                end
                ST_ITER: begin
                    if (trial_ok) begin
                        work_reg <= {trial_low, work_reg[DATA_W-2:0], 1'b1};
                    end else begin
                        work_reg <= {work_reg[WORK_W-2:0], 1'b0};
                    end
                    count_reg <= count_reg + CNT_W'(1);
                end
                ST_FIX: begin
                    // Divide-by-zero forces an all-ones quotient; the remainder
                    // then naturally equals the captured dividend.
                    if (!div_cancel) begin
                        s_reg <= y_zero_reg ? DATA_W'(DIV_ZERO_QUOT) : q_fix;
                        r_reg <= r_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s = s_reg;
    assign r = r_reg;

endmodule

// File: tb/tb_div_iter.sv
// Directed checks of div_iter: results, exact latency, busy window,
// operand hold, back-to-back requests, cancel and asynchronous reset.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        div, div_signed, div_cancel;
    logic [31:0] x, y;
    logic [31:0] s, r;
    logic        div_complete, div_busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div_iter dut (
        .clk          (clk),
        .reset        (reset),
        .div          (div),
        .div_signed   (div_signed),
        .div_cancel   (div_cancel),
        .x            (x),
        .y            (y),
        .s            (s),
        .r            (r),
        .div_complete (div_complete),
        .div_busy     (div_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request and follows it to div_complete; k is the cycle
    // offset from the sampling edge, so completion must land on k == 35.
    task automatic do_div(input string tag, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] es, input logic [31:0] er);
        int k;
        @(negedge clk);
        div = 1'b1; div_signed = sgn; x = a; y = b;
        @(negedge clk);
        div = 1'b0;
        k = 1;
        while (div_complete !== 1'b1 && k < 60) begin
            check({tag, "/busy"}, {31'b0, div_busy}, {31'b0, (k <= 34)});
            if (k == 5) begin
                x = $urandom; y = $urandom; div_signed = ~sgn;
            end
            @(negedge clk);
            k++;
        end
        check({tag, "/lat"}, 32'(k), 32'd35);
        check({tag, "/s"}, s, es);
        check({tag, "/r"}, r, er);
        $display("op %-10s signed=%0d x=%h y=%h -> s=%h r=%h latency=%0d",
                 tag, sgn, a, b, s, r, k);
    endtask

    initial begin
        int k;
        reset = 1'b1; div = 1'b0; div_signed = 1'b0; div_cancel = 1'b0;
        x = '0; y = '0;
        repeat (2) @(negedge clk);
        check("rst/s", s, 32'h0);
        check("rst/r", r, 32'h0);
        check("rst/busy", {31'b0, div_busy}, 32'h0);
        check("rst/done", {31'b0, div_complete}, 32'h0);
        reset = 1'b0;

        do_div("u100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2);
        do_div("s-7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF);
        do_div("s7_-2",    1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1);
        do_div("s-7_-2",   1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF);
        do_div("s_ovf",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0);
        do_div("u_max_1",  1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0);
        do_div("u_max_m1", 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          32'd1);
        do_div("u_div0",   1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678);
        do_div("s_div0",   1'b1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678);
        do_div("s_neg0",   1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9);

        // Back-to-back: div held high; second request starts in the IDLE
        // cycle after the first completion.
        @(negedge clk);
        div = 1'b1; div_signed = 1'b0; x = 32'd1000; y = 32'd9;
        @(negedge clk);
        k = 1;
        while (div_complete !== 1'b1 && k < 60) begin
            if (k == 5) begin x = 32'hDEAD_BEEF; y = 32'd3; end
            @(negedge clk);
            k++;
        end
        check("b2b1/lat", 32'(k), 32'd35);
        check("b2b1/s", s, 32'd111);
        check("b2b1/r", r, 32'd1);
        $display("op b2b_first  x=%h y=%h -> s=%h r=%h latency=%0d", 32'd1000, 32'd9, s, r, k);
        x = 32'd50; y = 32'd5;
        @(negedge clk);
        k++;
        while (div_complete !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("b2b2/lat", 32'(k), 32'd71);
        check("b2b2/s", s, 32'd10);
        check("b2b2/r", r, 32'd0);
        $display("op b2b_second x=%h y=%h -> s=%h r=%h latency=%0d", 32'd50, 32'd5, s, r, k);
        div = 1'b0;

        // Cancel at T+10: no completion, results untouched.
        @(negedge clk);
        div = 1'b1; div_signed = 1'b0; x = 32'd1000; y = 32'd3;
        @(negedge clk);
        div = 1'b0;
        for (k = 1; k <= 40; k++) begin
            if (k == 10) div_cancel = 1'b1;
            if (k == 11) div_cancel = 1'b0;
            check("cancel/done", {31'b0, div_complete}, 32'h0);
            if (k >= 11) check("cancel/busy", {31'b0, div_busy}, 32'h0);
            @(negedge clk);
        end
        check("cancel/s", s, 32'd10);
        check("cancel/r", r, 32'd0);
        $display("op cancel     x=%h y=%h -> s=%h r=%h (unchanged)", 32'd1000, 32'd3, s, r);

        // Asynchronous reset mid-operation, then a normal request.
        @(negedge clk);
        div = 1'b1; div_signed = 1'b0; x = 32'd500; y = 32'd7;
        @(negedge clk);
        div = 1'b0;
        for (k = 1; k < 20; k++) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst/s", s, 32'h0);
        check("arst/r", r, 32'h0);
        check("arst/busy", {31'b0, div_busy}, 32'h0);
        check("arst/done", {31'b0, div_complete}, 32'h0);
        $display("op async_rst  -> s=%h r=%h busy=%0d done=%0d", s, r, div_busy, div_complete);
        @(negedge clk);
        reset = 1'b0;
        do_div("post_rst", 1'b0, 32'd500, 32'd7, 32'd71, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Iterative radix-2 restoring divider; the responder end of the ALU's `div` / `div_complete` request handshake.
- Produces quotient `s` and remainder `r` for LoongArch DIV.W/DIVU.W/MOD.W/MOD.WU.
- The ALU selects `s` or `r` and holds the EX stage until `div_complete`.
- Replaces the long-latency combinational path with a fixed-latency multicycle FSM.

Parameters:
- DATA_W, 32, operand/result width (only 32 is supported and verified)

Ports:
- clk  input  1  clock; all state on rising edge
- reset  input  1  asynchronous, active-high reset
- div  input  1  request; sampled only in IDLE
- div_signed  input  1  1 = signed (DIV.W/MOD.W), 0 = unsigned
- div_cancel  input  1  pipeline flush; aborts any in-flight operation
- x  input  DATA_W  dividend
- y  input  DATA_W  divisor
- s  output  DATA_W  quotient, registered
- r  output  DATA_W  remainder, registered
- div_complete  output  1  result valid; one-cycle pulse
- div_busy  output  1  high in PREP/ITER/FIX

Behaviour:
- Reset (async, active-high): state=IDLE; s=0, r=0, div_complete=0, div_busy=0; counter and datapath registers cleared.
- States: IDLE, PREP, ITER, FIX, DONE (one-hot or binary; encoding is free).
- IDLE:
  - div=1 & div_cancel=0 -> PREP.
  - Capture x, y, div_signed into internal registers. Later changes on x/y/div_signed are ignored until the next start.
- PREP (1 cycle):
  - Compute |x| and |y| (magnitude only if div_signed=1).
  - Record q_neg = sign(x)^sign(y) and r_neg = sign(x), both only when signed.
  - Load the 64-bit working register {32'b0, |x|}; count=0 -> ITER.
- ITER (exactly 32 cycles, count 0..31):
  - Shift the working register left 1.
  - Trial = upper33 - {1'b0,|y|}.
  - If non-negative: upper32 = trial[31:0] and LSB = 1; else LSB = 0.
  - count==31 -> FIX.
- FIX (1 cycle):
  - Quotient = q_neg ? -lower32 : lower32; remainder = r_neg ? -upper32 : upper32.
  - Quotient rounds toward zero; remainder takes the sign of the dividend.
  - Register into s/r -> DONE.
- DONE (1 cycle): div_complete=1; unconditionally -> IDLE.
- s/r hold their value until the next FIX (or reset).
- Latency: div first sampled high in IDLE at cycle T -> div_complete high in cycle T+35 only.
- Requester contract:
  - The requester consumes s/r on the div_complete pulse.
  - If div is still high in the following IDLE cycle, it is a new request and starts a new operation.
  - Back-to-back throughput is one result per 36 cycles.
- Divide by zero (y==0), both modes: s=32'hFFFF_FFFF, r=x as captured.
  - The FSM still takes the full 35 cycles; no exception is raised.
- Overflow: signed 32'h8000_0000 / 32'hFFFF_FFFF -> s=32'h8000_0000, r=0. Natural two's-complement wrap; no special case required.
- div_cancel:
  - In any state other than IDLE -> IDLE next cycle. No div_complete is issued; s/r are unchanged.
  - Cancel in DONE: div_complete is still high that cycle, since it is combinational from state; the requester ignores it.
  - div & div_cancel both high in IDLE -> no start.
- div_busy = state in {PREP, ITER, FIX}; it is 0 in IDLE and DONE.
- Reset mid-operation: immediate return to the reset values; no partial result is visible.

Decomposition:
- Shared package:
  - DATA_W default
  - FSM state encoding constants
  - DIV_ITERS=32
  - DIV_LATENCY=35, for the bench and for hazard logic
  - the div-by-zero quotient constant 32'hFFFF_FFFF
- One natural sub-module, `div_sign_fix`: combinational conditional two's-complement negate, instantiated for |x|, |y|, quotient fix and remainder fix.
- The FSM and the shift/subtract datapath stay in `div_iter`.

Test Plan:
- Unsigned: div=1, div_signed=0, x=100, y=7 at T -> div_complete only at T+35; s=14, r=2. div_busy high T+1..T+34.
- Signed signs:
  - x=-7 (FFFFFFF9), y=2 -> s=FFFFFFFD, r=FFFFFFFF.
  - x=7, y=-2 -> s=FFFFFFFD, r=1.
  - x=-7, y=-2 -> s=3, r=FFFFFFFF.
- Edges:
  - Signed 80000000/FFFFFFFF -> s=80000000, r=0.
  - Unsigned FFFFFFFF/1 -> s=FFFFFFFF, r=0.
  - x=0x12345678, y=0 in both modes -> s=FFFFFFFF, r=12345678.
- Operand hold and back-to-back:
  - Change x/y at T+5 -> result still reflects the captured values.
  - Keep div high through T+36 with new operands 50/5 -> second div_complete at T+71 with s=10, r=0.
- div_cancel=1 at T+10 -> IDLE at T+11. No div_complete through T+40; s/r keep their prior values.
- Reset asserted asynchronously mid-cycle at T+20 -> s=0, r=0, div_busy=0, div_complete=0 before the next clock edge. A new request after release completes normally 35 cycles later.
